// File: rtl/ps2_inreg.sv
// PS/2 keyboard receiver and Gigatron button mapper feeding the CPU inreg port.
// Ports: clock/reset, raw ps2_clk/ps2_data in; inreg (active-low), rx_byte, rx_valid, rx_error out.
module ps2_inreg #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] inreg,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic          ext, brk;
  logic          ev, tmo, good;
  logic          hit;
  logic [7:0]    mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // fclk follows the synchronised clock only after FILTER
  // consecutive samples that differ from its current level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 == fclk) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER - 1)) begin
      fclk <= clk_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign ev   = fclk && !clk_s2 && (fcnt == FW'(FILTER - 1));
  assign tmo  = (state != IDLE) && !ev && (tcnt == TW'(TIMEOUT - 1));
  assign good = dat_s2 && ^{shreg, par};

  function automatic logic [8:0] lookup(input logic e, input logic [7:0] b);
    logic [8:0] r;
    r = 9'h000;
    case ({e, b})
      9'h174:  r = 9'h101;
      9'h16B:  r = 9'h102;
      9'h172:  r = 9'h104;
      9'h175:  r = 9'h108;
      9'h05A:  r = 9'h110;
      9'h00D:  r = 9'h120;
      9'h01A:  r = 9'h140;
      9'h022:  r = 9'h180;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign {hit, mask} = lookup(ext, shreg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      inreg    <= 8'hFF;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;

      if (state == IDLE || ev)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + 1'b1;

      if (tmo) begin
        state    <= IDLE;
        rx_error <= 1'b1;
        ext      <= 1'b0;
        brk      <= 1'b0;
      end else if (ev) begin
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (good) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                if (hit)
                  inreg <= brk ? (inreg | mask) : (inreg & ~mask);
                ext <= 1'b0;
                brk <= 1'b0;
              end
            end else begin
              rx_error <= 1'b1;
              ext      <= 1'b0;
              brk      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
